// File: rtl/seq_detect_ctrl_if.sv
// Host config, run control, serial bit source and status bundle of the
// programmable pattern detector.
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               a;
  logic               a_valid;
  logic               detected;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, a, a_valid,
    input  cfg_ready, detected, match_cnt, busy, done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, a, a_valid,
    output cfg_ready, detected, match_cnt, busy, done, cfg_err
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector run controller; detected is registered (1-cycle latency).
// Define SEQ_DETECT_CTRL_NO_OVERLAP_EN to forbid matches sharing bits.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic            clk,
  input logic            rst,
  seq_detect_ctrl_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t             r_state, w_state_n;
  logic [MAX_LEN-1:0] r_pat, w_pat_n, r_win, w_win_n, w_win_sh, w_mask;
  logic [LEN_W-1:0]   r_len, w_len_n, r_fill, w_fill_n, w_fill_inc;
  logic [CNT_W-1:0]   r_tgt, w_tgt_n, r_cnt, w_cnt_n, w_cnt_inc;
  logic               r_rdy, w_rdy_n, r_det, w_det_n, r_err, w_err_n;
  logic               w_cfg_ok, w_match;

  // Match is judged on the window as it will look after shifting in this bit.
  always_comb begin
    w_win_sh   = (r_win << 1) | MAX_LEN'(bus.a);
    w_fill_inc = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
    w_cnt_inc  = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
    w_cfg_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);
    w_mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
    w_match = (w_fill_inc >= r_len) && (((w_win_sh ^ r_pat) & w_mask) == '0);
  end

  always_comb begin
    w_state_n = r_state;
    w_pat_n   = r_pat;
    w_len_n   = r_len;
    w_tgt_n   = r_tgt;
    w_win_n   = r_win;
    w_fill_n  = r_fill;
    w_cnt_n   = r_cnt;
    w_det_n   = 1'b0;
    w_err_n   = 1'b0;
    if (bus.abort) begin
      w_state_n = IDLE;
      w_win_n   = '0;
      w_fill_n  = '0;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.cfg_valid) begin
            if (w_cfg_ok) begin
              w_pat_n   = bus.cfg_pattern;
              w_len_n   = bus.cfg_len;
              w_tgt_n   = bus.cfg_target;
              w_win_n   = '0;
              w_fill_n  = '0;
              w_cnt_n   = '0;
              w_state_n = ARMED;
            end else begin
              w_err_n   = 1'b1;
              w_state_n = IDLE;
            end
          end
        end
        ARMED: begin
          if (bus.start) w_state_n = RUN;
        end
        RUN: begin
          if (bus.a_valid) begin
            w_win_n  = w_win_sh;
            w_fill_n = w_fill_inc;
            if (w_match) begin
              w_det_n = 1'b1;
              w_cnt_n = w_cnt_inc;
`ifdef SEQ_DETECT_CTRL_NO_OVERLAP_EN
              w_fill_n = '0;
`else
              w_fill_n = w_fill_inc;
`endif
              if ((r_tgt != '0) && (w_cnt_inc == r_tgt)) w_state_n = DONE;
            end
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
    // Registered so that cfg_ready reads 0 while reset is held.
    w_rdy_n = (w_state_n == IDLE) || (w_state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_tgt   <= '0;
      r_win   <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
      r_det   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pat   <= w_pat_n;
      r_len   <= w_len_n;
      r_tgt   <= w_tgt_n;
      r_win   <= w_win_n;
      r_fill  <= w_fill_n;
      r_cnt   <= w_cnt_n;
      r_rdy   <= w_rdy_n;
      r_det   <= w_det_n;
      r_err   <= w_err_n;
    end
  end

  assign bus.cfg_ready = r_rdy;
  assign bus.detected  = r_det;
  assign bus.match_cnt = r_cnt;
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == DONE);
  assign bus.cfg_err   = r_err;
endmodule
